// File: rtl/register_file_banked.sv
// rtl/register_file_banked.sv - banked register file, byte-lane writes, two registered read ports, sequenced clear
module register_file_banked #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4,
    parameter int BANKS  = 2,
    parameter int BYPASS = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [ADDR_W-1:0]          RD_A_ADDR,
    output logic [WIDTH-1:0]           RD_A_DATA,
    input  logic [ADDR_W-1:0]          RD_B_ADDR,
    output logic [WIDTH-1:0]           RD_B_DATA,
    input  logic [ADDR_W-1:0]          WR_ADDR,
    input  logic [WIDTH-1:0]           WR_DATA,
    input  logic [WIDTH/8-1:0]         WR_EN,
    input  logic                       BANK_REQ,
    input  logic [$clog2(BANKS)-1:0]   BANK_REQ_ID,
    output logic [$clog2(BANKS)-1:0]   CUR_BANK,
    input  logic                       CLR_REQ,
    output logic                       BUSY
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BANK_W = $clog2(BANKS);
    localparam int LANES  = WIDTH / 8;
    localparam int CNT_W  = ADDR_W + BANK_W;

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_all;
    logic [BANK_W-1:0]   r_clr_bank;
    logic [BANK_W-1:0]   r_cur_bank;
    logic [BANK_W-1:0]   r_pend_bank;
    logic                r_pend_v;
    logic [WIDTH-1:0]    r_rda;
    logic [WIDTH-1:0]    r_rdb;
    logic [WIDTH-1:0]    r_mem [0:BANKS*DEPTH-1];

    logic                w_busy;
    logic                w_wr_go;
    logic                w_last;
    logic [CNT_W-1:0]    w_clr_idx;
    logic [CNT_W-1:0]    w_wr_idx;
    logic [WIDTH-1:0]    w_mask;
    logic [WIDTH-1:0]    w_wr_merged;
    logic [WIDTH-1:0]    w_rda_val;
    logic [WIDTH-1:0]    w_rdb_val;

    assign w_busy      = (r_state == S_CLEAR);
    // An accepted clear request drops any write issued in the same cycle.
    assign w_wr_go     = !w_busy && !CLR_REQ && (|WR_EN);
    assign w_last      = r_all ? (&r_cnt) : (&r_cnt[ADDR_W-1:0]);
    assign w_clr_idx   = r_all ? r_cnt : {r_clr_bank, r_cnt[ADDR_W-1:0]};
    assign w_wr_idx    = {r_cur_bank, WR_ADDR};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mask[8*i +: 8] = {8{WR_EN[i]}};
        end
    end

    assign w_wr_merged = (r_mem[w_wr_idx] & ~w_mask) | (WR_DATA & w_mask);

    assign w_rda_val = (BYPASS != 0 && w_wr_go && RD_A_ADDR == WR_ADDR) ?
                       w_wr_merged : r_mem[{r_cur_bank, RD_A_ADDR}];
    assign w_rdb_val = (BYPASS != 0 && w_wr_go && RD_B_ADDR == WR_ADDR) ?
                       w_wr_merged : r_mem[{r_cur_bank, RD_B_ADDR}];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (CLR_REQ) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY      = w_busy;
        CUR_BANK  = r_cur_bank;
        RD_A_DATA = r_rda;
        RD_B_DATA = r_rdb;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt       <= '0;
            r_all       <= 1'b1;
            r_clr_bank  <= '0;
            r_cur_bank  <= '0;
            r_pend_bank <= '0;
            r_pend_v    <= 1'b0;
            r_rda       <= '0;
            r_rdb       <= '0;
        end else if (r_state == S_IDLE) begin
            r_rda <= w_rda_val;
            r_rdb <= w_rdb_val;
            if (BANK_REQ) r_cur_bank <= BANK_REQ_ID;
            if (CLR_REQ) begin
                r_all      <= 1'b0;
                r_cnt      <= '0;
                r_clr_bank <= BANK_REQ ? BANK_REQ_ID : r_cur_bank;
            end
        end else begin
            r_rda <= '0;
            r_rdb <= '0;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            // A request arriving on the final clear edge is the latest one and wins.
            if (w_last) begin
                if (BANK_REQ)      r_cur_bank <= BANK_REQ_ID;
                else if (r_pend_v) r_cur_bank <= r_pend_bank;
                r_pend_v <= 1'b0;
            end else if (BANK_REQ) begin
                r_pend_v    <= 1'b1;
                r_pend_bank <= BANK_REQ_ID;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (w_busy) begin
                r_mem[w_clr_idx] <= '0;
            end else if (w_wr_go) begin
                r_mem[w_wr_idx] <= w_wr_merged;
            end
        end
    end
endmodule

// File: tb/tb_register_file_banked.sv
// tb/tb_register_file_banked.sv - randomized and directed bench against a queue-based reference model
module tb_register_file_banked;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;
    localparam int BANKS  = 2;
    localparam int DEPTH  = 16;
    localparam int BYPASS = 1;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [ADDR_W-1:0] RD_A_ADDR, RD_B_ADDR, WR_ADDR;
    logic [WIDTH-1:0]  RD_A_DATA, RD_B_DATA, WR_DATA;
    logic [1:0]        WR_EN;
    logic              BANK_REQ, CLR_REQ, BUSY;
    logic [0:0]        BANK_REQ_ID, CUR_BANK;

    int n_checks = 0;
    int n_errors = 0;

    register_file_banked #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BANKS(BANKS), .BYPASS(BYPASS)) dut (
        .CLK(CLK), .RESET(RESET),
        .RD_A_ADDR(RD_A_ADDR), .RD_A_DATA(RD_A_DATA),
        .RD_B_ADDR(RD_B_ADDR), .RD_B_DATA(RD_B_DATA),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
        .BANK_REQ(BANK_REQ), .BANK_REQ_ID(BANK_REQ_ID), .CUR_BANK(CUR_BANK),
        .CLR_REQ(CLR_REQ), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain arrays plus a queue of entries still waiting to be zeroed.
    logic [WIDTH-1:0] m_mem [0:BANKS-1][0:DEPTH-1];
    int               m_bank = 0;
    bit               m_pend_v = 0;
    int               m_pend = 0;
    int               m_clrq[$];
    logic [WIDTH-1:0] m_rda = '0;
    logic [WIDTH-1:0] m_rdb = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] nw;
        int e, tgt;
        if (RESET) begin
            m_clrq.delete();
            for (int i = 0; i < BANKS*DEPTH; i++) m_clrq.push_back(i);
            m_bank = 0; m_pend_v = 0; m_rda = '0; m_rdb = '0;
        end else if (m_clrq.size() > 0) begin
            e = m_clrq.pop_front();
            m_mem[e / DEPTH][e % DEPTH] = '0;
            m_rda = '0; m_rdb = '0;
            if (BANK_REQ) begin m_pend_v = 1; m_pend = int'(BANK_REQ_ID); end
            if (m_clrq.size() == 0 && m_pend_v) begin m_bank = m_pend; m_pend_v = 0; end
        end else begin
            nw = m_mem[m_bank][WR_ADDR];
            for (int i = 0; i < WIDTH/8; i++) if (WR_EN[i]) nw[8*i +: 8] = WR_DATA[8*i +: 8];
            m_rda = (BYPASS != 0 && !CLR_REQ && RD_A_ADDR == WR_ADDR) ? nw : m_mem[m_bank][RD_A_ADDR];
            m_rdb = (BYPASS != 0 && !CLR_REQ && RD_B_ADDR == WR_ADDR) ? nw : m_mem[m_bank][RD_B_ADDR];
            if (!CLR_REQ) m_mem[m_bank][WR_ADDR] = nw;
            if (CLR_REQ) begin
                tgt = BANK_REQ ? int'(BANK_REQ_ID) : m_bank;
                for (int a = 0; a < DEPTH; a++) m_clrq.push_back(tgt*DEPTH + a);
            end
            if (BANK_REQ) m_bank = int'(BANK_REQ_ID);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        check_eq("busy", {31'd0, BUSY}, {31'd0, m_clrq.size() > 0});
        check_eq("cur_bank", {31'd0, CUR_BANK}, m_bank);
        check_eq("rd_a", {16'd0, RD_A_DATA}, {16'd0, m_rda});
        check_eq("rd_b", {16'd0, RD_B_DATA}, {16'd0, m_rdb});
    endtask

    task automatic set_idle();
        RESET = 0; RD_A_ADDR = '0; RD_B_ADDR = '0; WR_ADDR = '0; WR_DATA = '0;
        WR_EN = '0; BANK_REQ = 0; BANK_REQ_ID = '0; CLR_REQ = 0;
    endtask

    task automatic go_bank(input int b);
        BANK_REQ = 1; BANK_REQ_ID = 1'(b); tick(); BANK_REQ = 0;
    endtask

    task automatic write(input int a, input int d, input logic [1:0] en);
        WR_ADDR = 4'(a); WR_DATA = 16'(d); WR_EN = en; tick(); WR_EN = '0;
    endtask

    task automatic read2(input int a, input int b);
        RD_A_ADDR = 4'(a); RD_B_ADDR = 4'(b); tick();
    endtask

    int n;

    initial begin
        set_idle();
        RESET = 1;
        tick(); tick();
        check_eq("reset_busy", {31'd0, BUSY}, 1);
        RESET = 0;
        n = 0;
        while (BUSY && n < 100) begin tick(); n++; end
        check_eq("reset_busy_len", n, 32);
        for (int b = 0; b < BANKS; b++) begin
            go_bank(b);
            for (int a = 0; a < DEPTH; a++) begin
                read2(a, DEPTH - 1 - a);
                check_eq("post_reset_zero_a", {16'd0, RD_A_DATA}, 0);
                check_eq("post_reset_zero_b", {16'd0, RD_B_DATA}, 0);
            end
        end

        go_bank(0);
        write(3, 16'hA55A, 2'b11);
        RD_A_ADDR = 3; RD_B_ADDR = 3;
        write(3, 16'h1234, 2'b01);
        check_eq("bypass_a", {16'd0, RD_A_DATA}, 32'hA534);
        check_eq("bypass_b", {16'd0, RD_B_DATA}, 32'hA534);
        read2(3, 0);
        check_eq("lane_merge", {16'd0, RD_A_DATA}, 32'hA534);

        write(5, 16'h1111, 2'b11);
        BANK_REQ = 1; BANK_REQ_ID = 1;
        write(6, 16'h3333, 2'b11);
        BANK_REQ = 0;
        write(5, 16'h2222, 2'b11);
        read2(5, 6);
        check_eq("bank1_r5", {16'd0, RD_A_DATA}, 32'h2222);
        go_bank(0);
        read2(5, 6);
        check_eq("bank0_r5", {16'd0, RD_A_DATA}, 32'h1111);
        check_eq("bank0_r6_switch_cycle", {16'd0, RD_B_DATA}, 32'h3333);

        go_bank(1);
        for (int a = 0; a < DEPTH; a++) write(a, 16'h0101 * a + 16'h10, 2'b11);
        CLR_REQ = 1; tick(); CLR_REQ = 0;
        n = 0;
        while (BUSY && n < 100) begin
            if (n == 5) begin CLR_REQ = 1; WR_ADDR = 2; WR_DATA = 16'hDEAD; WR_EN = 2'b11; end
            tick(); n++;
            CLR_REQ = 0; WR_EN = '0;
        end
        check_eq("clr_busy_len", n, 16);
        for (int a = 0; a < DEPTH; a++) begin
            read2(a, a);
            check_eq("bank1_cleared", {16'd0, RD_A_DATA}, 0);
        end
        go_bank(0);
        read2(5, 3);
        check_eq("bank0_kept_r5", {16'd0, RD_A_DATA}, 32'h1111);
        check_eq("bank0_kept_r3", {16'd0, RD_B_DATA}, 32'hA534);

        RESET = 1; tick(); RESET = 0;
        n = 0;
        while (BUSY && n < 100) begin
            if (n == 4) begin BANK_REQ = 1; BANK_REQ_ID = 1; end
            tick(); n++;
            BANK_REQ = 0;
            if (BUSY) check_eq("pend_hold_bank", {31'd0, CUR_BANK}, 0);
        end
        check_eq("pend_applied", {31'd0, CUR_BANK}, 1);

        RESET = 1; tick(); RESET = 0;
        for (int i = 0; i < 10; i++) tick();
        RESET = 1; tick(); RESET = 0;
        n = 0;
        while (BUSY && n < 100) begin
            if (n == 3) begin WR_ADDR = 7; WR_DATA = 16'hBEEF; WR_EN = 2'b11; end
            tick(); n++;
            WR_EN = '0;
        end
        check_eq("restart_busy_len", n, 32);
        read2(7, 7);
        check_eq("busy_write_dropped", {16'd0, RD_A_DATA}, 0);

        for (int i = 0; i < 3000; i++) begin
            RESET       = ($urandom % 600) == 0;
            RD_A_ADDR   = 4'($urandom);
            RD_B_ADDR   = ($urandom % 4 == 0) ? RD_A_ADDR : 4'($urandom);
            WR_ADDR     = ($urandom % 3 == 0) ? RD_A_ADDR : 4'($urandom);
            WR_DATA     = 16'($urandom);
            WR_EN       = 2'($urandom);
            BANK_REQ    = ($urandom % 10) == 0;
            BANK_REQ_ID = 1'($urandom);
            CLR_REQ     = ($urandom % 60) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
